// File: rtl/router_pkg.sv
// Shared definitions for the router input-side control path: FSM state
// encodings, default sizing and the reserved header address.
package router_pkg;

  localparam int unsigned NUM_PORTS_DEF = 3;
  localparam int unsigned ADDR_W_DEF    = 2;

  // Header address never mapped to an output port.
  localparam logic [1:0] INVALID_ADDR = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_e;

endpackage

// File: rtl/router_fsm_if.sv
// Signal bundle between router_fsm and its source, FIFOs and register stage.
// slave = the FSM side, master = the environment driving it.
interface router_fsm_if
  import router_pkg::*;
#(
  parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF
);

  logic                 pkt_valid;
  logic [ADDR_W-1:0]    data_in;
  logic                 fifo_full;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] soft_reset;
  logic                 parity_done;
  logic                 low_pkt_valid;

  logic                 detect_add;
  logic                 lfd_state;
  logic                 ld_state;
  logic                 laf_state;
  logic                 full_state;
  logic                 rst_int_reg;
  logic                 write_enb_reg;
  logic                 busy;
  logic [ADDR_W-1:0]    addr_lat;
  logic                 drop_pkt;

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
           parity_done, low_pkt_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, write_enb_reg, busy, addr_lat, drop_pkt
  );

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
           parity_done, low_pkt_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, write_enb_reg, busy, addr_lat, drop_pkt
  );

endinterface

// File: rtl/router_fsm.sv
// Packet-level control FSM for the router input side (Moore strobes).
// Optional WAIT_TILL_EMPTY timeout enabled by defining ROUTER_FSM_TIMEOUT_EN.
module router_fsm
  import router_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = NUM_PORTS_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 30
) (
  input  logic        clock,
  input  logic        reset,
  router_fsm_if.slave bus
);

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("router_fsm: TIMEOUT_CYC must be at least 2");
  end
  if (NUM_PORTS > (1 << ADDR_W)) begin : g_bad_ports
    $error("router_fsm: NUM_PORTS exceeds header address range");
  end

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q;
  logic [ADDR_W-1:0]    hdr_addr;
  logic                 hdr_valid;
  logic [NUM_PORTS-1:0] hdr_empty_sh, lat_empty_sh, lat_soft_sh;
  logic                 hdr_empty, lat_empty, lat_soft;
  logic                 wait_expired;

  assign hdr_addr  = bus.data_in;
  assign hdr_valid = 32'(hdr_addr) < NUM_PORTS;

  // Shift-select keeps out-of-range header codes from indexing past the
  // vectors; an invalid address simply reads as 0.
  assign hdr_empty_sh = bus.fifo_empty >> hdr_addr;
  assign lat_empty_sh = bus.fifo_empty >> addr_q;
  assign lat_soft_sh  = bus.soft_reset >> addr_q;
  assign hdr_empty    = hdr_empty_sh[0];
  assign lat_empty    = lat_empty_sh[0];
  assign lat_soft     = lat_soft_sh[0];

`ifdef ROUTER_FSM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else if (state_q == WAIT_TILL_EMPTY) begin
      wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end else begin
      wait_cnt_q <= '0;
    end
  end

  assign wait_expired = (state_q == WAIT_TILL_EMPTY) && !lat_empty &&
                        (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign wait_expired = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE_ADDRESS && bus.pkt_valid && hdr_valid) begin
        addr_q <= hdr_addr;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q != DECODE_ADDRESS && lat_soft) begin
      state_d = DECODE_ADDRESS;
    end else begin
      case (state_q)
        DECODE_ADDRESS: begin
          if (bus.pkt_valid && hdr_valid) begin
            state_d = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        LOAD_FIRST_DATA: state_d = LOAD_DATA;
        LOAD_DATA: begin
          if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
          else if (!bus.pkt_valid) state_d = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (bus.parity_done)        state_d = DECODE_ADDRESS;
          else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
          else                        state_d = LOAD_DATA;
        end
        LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        end
        WAIT_TILL_EMPTY: begin
          if (lat_empty)         state_d = LOAD_FIRST_DATA;
          else if (wait_expired) state_d = DECODE_ADDRESS;
        end
        default: state_d = DECODE_ADDRESS;
      endcase
    end
  end

  assign bus.detect_add    = (state_q == DECODE_ADDRESS);
  assign bus.lfd_state     = (state_q == LOAD_FIRST_DATA);
  assign bus.ld_state      = (state_q == LOAD_DATA);
  assign bus.laf_state     = (state_q == LOAD_AFTER_FULL);
  assign bus.full_state    = (state_q == FIFO_FULL_STATE);
  assign bus.rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
  assign bus.write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                             (state_q == LOAD_AFTER_FULL);
  assign bus.busy          = (state_q != DECODE_ADDRESS) && (state_q != LOAD_DATA);
  assign bus.addr_lat      = addr_q;
  // A soft reset in the same cycle takes the FSM out through its own path.
  assign bus.drop_pkt      = wait_expired && !lat_soft;

endmodule
